qtable_banked_argmax: RTL

//  Parametrised Q-table for the Q-learning datapath: one BRAM bank per action, indexed by state.
//  A single read returns the Q-values of all actions for a state, plus the max Q and its argmax action.

---
 rtl/qtable_banked_argmax_if.sv | 34 +++
 rtl/qtable_banked_argmax.sv | 130 +++++++++++++
 2 files changed

// File: rtl/qtable_banked_argmax_if.sv
// Request/response bundle for the banked Q-table: clear control, read port and write port.
// Signal names carry the table's own direction (i_ into the table, o_ out of it).
interface qtable_banked_argmax_if #(
  parameter int unsigned STATE_WIDTH  = 6,
  parameter int unsigned ACTION_WIDTH = 2,
  parameter int unsigned DATA_WIDTH   = 32
);
  localparam int unsigned NUM_ACTIONS = 2 ** ACTION_WIDTH;

  logic                              i_clear;
  logic                              o_busy;
  logic                              i_rd_valid;
  logic [STATE_WIDTH-1:0]            i_rd_state;
  logic                              o_rd_ready;
  logic                              o_rd_valid;
  logic [DATA_WIDTH*NUM_ACTIONS-1:0] o_rd_q;
  logic [DATA_WIDTH-1:0]             o_rd_max_q;
  logic [ACTION_WIDTH-1:0]           o_rd_max_action;
  logic                              i_wr_valid;
  logic [STATE_WIDTH-1:0]            i_wr_state;
  logic [ACTION_WIDTH-1:0]           i_wr_action;
  logic [DATA_WIDTH-1:0]             i_wr_data;
  logic                              o_wr_ready;

  modport slave (
    input  i_clear, i_rd_valid, i_rd_state, i_wr_valid, i_wr_state, i_wr_action, i_wr_data,
    output o_busy, o_rd_ready, o_rd_valid, o_rd_q, o_rd_max_q, o_rd_max_action, o_wr_ready
  );

  modport master (
    output i_clear, i_rd_valid, i_rd_state, i_wr_valid, i_wr_state, i_wr_action, i_wr_data,
    input  o_busy, o_rd_ready, o_rd_valid, o_rd_q, o_rd_max_q, o_rd_max_action, o_wr_ready
  );
endinterface

// File: rtl/qtable_banked_argmax.sv
// Banked Q-table (one bank per action) with 2-stage read, signed argmax and a sequential clear sweep.
// Define QTABLE_BYPASS_EN for read-after-write forwarding; otherwise reads are read-first.
module qtable_banked_argmax #(
  parameter int unsigned           STATE_WIDTH  = 6,
  parameter int unsigned           ACTION_WIDTH = 2,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input logic                     i_clk,
  input logic                     i_rst,
  qtable_banked_argmax_if.slave   bus
);
  localparam int unsigned NUM_ACTIONS = 2 ** ACTION_WIDTH;
  localparam int unsigned DEPTH       = 2 ** STATE_WIDTH;

  typedef enum logic {StClear, StRun} state_e;

  state_e                            r_state, w_state_next;
  logic [STATE_WIDTH-1:0]            r_cnt;
  logic                              w_run, w_rd_en, w_wr_en, w_clr_en;
  logic                              r_s1_valid;
  logic [DATA_WIDTH-1:0]             w_lane [NUM_ACTIONS];
  logic [DATA_WIDTH-1:0]             w_max_q;
  logic [ACTION_WIDTH-1:0]           w_max_a;
  logic                              r_rd_valid;
  logic [DATA_WIDTH*NUM_ACTIONS-1:0] r_rd_q;
  logic [DATA_WIDTH-1:0]             r_rd_max_q;
  logic [ACTION_WIDTH-1:0]           r_rd_max_a;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StClear;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StClear: if (r_cnt == {STATE_WIDTH{1'b1}}) w_state_next = StRun;
      StRun:   if (bus.i_clear) w_state_next = StClear;
      default: w_state_next = StClear;
    endcase
  end

  always_comb begin
    w_run          = (r_state == StRun) && !i_rst;
    bus.o_busy     = (r_state == StClear) || i_rst;
    bus.o_rd_ready = w_run;
    bus.o_wr_ready = w_run;
  end

  assign w_rd_en  = bus.i_rd_valid && w_run;
  assign w_wr_en  = bus.i_wr_valid && w_run;
  assign w_clr_en = (r_state == StClear) && !i_rst;

  // Counter is held at 0 outside the sweep so every sweep starts at entry 0.
  always_ff @(posedge i_clk) begin
    if (i_rst || r_state != StClear) r_cnt <= '0;
    else                             r_cnt <= r_cnt + 1'b1;
  end

`ifdef QTABLE_BYPASS_EN
  logic [STATE_WIDTH-1:0] r_s1_state;
  always_ff @(posedge i_clk) begin
    if (w_rd_en) r_s1_state <= bus.i_rd_state;
  end
`endif

  for (genvar a = 0; a < NUM_ACTIONS; a++) begin : g_bank
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_s1_q;
    logic                  w_wr_hit;

    assign w_wr_hit = w_wr_en && (bus.i_wr_action == ACTION_WIDTH'(a));

    always_ff @(posedge i_clk) begin
      if (w_clr_en)      r_mem[r_cnt]          <= INIT_VALUE;
      else if (w_wr_hit) r_mem[bus.i_wr_state] <= bus.i_wr_data;
`ifdef QTABLE_BYPASS_EN
      if (w_rd_en) r_s1_q <= (w_wr_hit && bus.i_wr_state == bus.i_rd_state) ? bus.i_wr_data
                                                                             : r_mem[bus.i_rd_state];
`else
      if (w_rd_en) r_s1_q <= r_mem[bus.i_rd_state];
`endif
    end

`ifdef QTABLE_BYPASS_EN
    // A write landing while the read sits in stage 1 still replaces its lane.
    assign w_lane[a] = (w_wr_hit && bus.i_wr_state == r_s1_state) ? bus.i_wr_data : r_s1_q;
`else
    assign w_lane[a] = r_s1_q;
`endif
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    w_max_q = w_lane[0];
    w_max_a = '0;
    for (int unsigned a = 1; a < NUM_ACTIONS; a++) begin
      if ($signed(w_lane[a]) > $signed(w_max_q)) begin
        w_max_q = w_lane[a];
        w_max_a = ACTION_WIDTH'(a);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_q     <= '0;
      r_rd_max_q <= '0;
      r_rd_max_a <= '0;
    end else begin
      r_s1_valid <= w_rd_en;
      r_rd_valid <= r_s1_valid;
      if (r_s1_valid) begin
        for (int unsigned a = 0; a < NUM_ACTIONS; a++) begin
          r_rd_q[a*DATA_WIDTH +: DATA_WIDTH] <= w_lane[a];
        end
        r_rd_max_q <= w_max_q;
        r_rd_max_a <= w_max_a;
      end
    end
  end

  assign bus.o_rd_valid      = r_rd_valid;
  assign bus.o_rd_q          = r_rd_q;
  assign bus.o_rd_max_q      = r_rd_max_q;
  assign bus.o_rd_max_action = r_rd_max_a;
endmodule
